scalar_integer_issue: RTL and testbench

Issue-and-writeback controller that drives the scalar integer functional unit (opcodes 104–107 octal) and retires its results. Owns the eight 64-bit S registers and a busy scoreboard. Decodes instruction parcels, reads Sj/Sk, issues operands and opcode, and writes the returned Si back after the unit's fixed two-cycle functional time. Sits between the instruction buffer/decode stage and the functional unit.

---
 rtl/scalar_integer_issue_pkg.sv | 25 ++
 rtl/scalar_integer_issue_if.sv | 26 ++
 rtl/scalar_integer_issue_scoreboard.sv | 44 ++++
 rtl/scalar_integer_issue.sv | 87 ++++++++
 tb/tb_scalar_integer_issue.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/scalar_integer_issue_pkg.sv
// scalar_pkg: opcodes, latency and parcel/writeback types for the scalar integer issue block
package scalar_pkg;
   localparam logic [6:0] OP_SUM  = 7'o104;
   localparam logic [6:0] OP_DIFF = 7'o105;
   localparam logic [6:0] OP_POP  = 7'o106;
   localparam logic [6:0] OP_LZC  = 7'o107;
   localparam int FU_LATENCY = 2;
   typedef struct packed {
      logic [6:0] opcode;
      logic [2:0] i;
      logic [2:0] j;
      logic [2:0] k;
   } parcel_t;
   typedef struct packed {
      logic       v;
      logic [2:0] d;
   } wb_t;
   // 104..107 share the upper five opcode bits
   function automatic logic is_legal(input logic [6:0] op);
      return op[6:2] == OP_SUM[6:2];
   endfunction
   function automatic logic uses_k(input logic [6:0] op);
      return op[6:1] == OP_SUM[6:1];
   endfunction
endpackage

// File: rtl/scalar_integer_issue_if.sv
// scalar_integer_issue_if: parcel, load, debug-read and functional-unit signals of the issue block
interface scalar_integer_issue_if;
   logic        i_Valid;
   logic [15:0] i_Parcel;
   logic        o_Ready;
   logic        i_LdValid;
   logic [2:0]  i_LdAddr;
   logic [63:0] i_LdData;
   logic        o_LdReady;
   logic [2:0]  i_RdAddr;
   logic [63:0] o_RdData;
   logic [63:0] o_Sj;
   logic [63:0] o_Sk;
   logic [6:0]  o_Instr;
   logic [63:0] i_Si;
   logic        o_Illegal;
   logic        o_Busy;
   modport master (
      output i_Valid, i_Parcel, i_LdValid, i_LdAddr, i_LdData, i_RdAddr, i_Si,
      input  o_Ready, o_LdReady, o_RdData, o_Sj, o_Sk, o_Instr, o_Illegal, o_Busy
   );
   modport slave (
      input  i_Valid, i_Parcel, i_LdValid, i_LdAddr, i_LdData, i_RdAddr, i_Si,
      output o_Ready, o_LdReady, o_RdData, o_Sj, o_Sk, o_Instr, o_Illegal, o_Busy
   );
endinterface

// File: rtl/scalar_integer_issue_scoreboard.sv
// s_register_scoreboard: eight 64-bit S registers with three read ports, two write ports and busy bits
module s_register_scoreboard (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  i_AddrJ,
   input  logic [2:0]  i_AddrK,
   input  logic [2:0]  i_AddrDbg,
   output logic [63:0] o_DataJ,
   output logic [63:0] o_DataK,
   output logic [63:0] o_DataDbg,
   input  logic        i_WbEn,
   input  logic [2:0]  i_WbAddr,
   input  logic [63:0] i_WbData,
   input  logic        i_LdEn,
   input  logic [2:0]  i_LdAddr,
   input  logic [63:0] i_LdData,
   input  logic        i_SetEn,
   input  logic [2:0]  i_SetAddr,
   input  logic        i_ClrEn,
   input  logic [2:0]  i_ClrAddr,
   output logic [7:0]  o_Busy
);
   logic [63:0] r_S [8];
   logic [7:0]  r_busy;
   logic [7:0]  w_set;
   logic [7:0]  w_clr;
   assign o_DataJ   = r_S[i_AddrJ];
   assign o_DataK   = r_S[i_AddrK];
   assign o_DataDbg = r_S[i_AddrDbg];
   assign o_Busy    = r_busy;
   assign w_set     = {7'b0, i_SetEn} << i_SetAddr;
   assign w_clr     = {7'b0, i_ClrEn} << i_ClrAddr;
   // the scoreboard keeps writeback and load targets disjoint, so write order is irrelevant
   always_ff @(posedge clk) begin
      if (rst) begin
         r_S    <= '{default: '0};
         r_busy <= '0;
      end else begin
         if (i_WbEn) r_S[i_WbAddr] <= i_WbData;
         if (i_LdEn) r_S[i_LdAddr] <= i_LdData;
         r_busy <= (r_busy | w_set) & ~w_clr;
      end
   end
endmodule

// File: rtl/scalar_integer_issue.sv
// scalar_integer_issue: issues 104-107 parcels to the scalar integer unit and retires results into S
module scalar_integer_issue #(
   parameter int FU_LATENCY = scalar_pkg::FU_LATENCY
) (
   input logic clk,
   input logic rst,
   scalar_integer_issue_if.slave bus
);
   import scalar_pkg::*;
   parcel_t             w_p;
   logic [7:0]          w_busy;
   logic [63:0]         w_sj;
   logic [63:0]         w_sk;
   logic                w_legal;
   logic                w_usek;
   logic                w_hazard;
   logic                w_acc;
   logic                w_issue;
   logic                w_ld;
   logic                w_inflight;
   wb_t                 w_new;
   wb_t                 w_tail;
   wb_t [FU_LATENCY:0]  r_pipe;
   logic [63:0]         r_Sj;
   logic [63:0]         r_Sk;
   logic [6:0]          r_Instr;
   logic                r_Illegal;
   assign w_p      = parcel_t'(bus.i_Parcel);
   assign w_legal  = is_legal(w_p.opcode);
   assign w_usek   = uses_k(w_p.opcode);
   assign w_hazard = w_busy[w_p.i] | w_busy[w_p.j] | (w_usek & w_busy[w_p.k]);
   assign bus.o_Ready   = ~rst & ~bus.i_LdValid & (~w_legal | ~w_hazard);
   assign w_acc    = bus.i_Valid & bus.o_Ready;
   assign w_issue  = w_acc & w_legal;
   assign bus.o_LdReady = ~rst & ~w_busy[bus.i_LdAddr];
   assign w_ld     = bus.i_LdValid & bus.o_LdReady;
   assign w_new    = '{v: w_issue, d: w_p.i};
   assign w_tail   = r_pipe[FU_LATENCY];
   assign bus.o_Sj      = r_Sj;
   assign bus.o_Sk      = r_Sk;
   assign bus.o_Instr   = r_Instr;
   assign bus.o_Illegal = r_Illegal;
   assign bus.o_Busy    = ~rst & ((|w_busy) | w_inflight);
   always_comb begin
      w_inflight = 1'b0;
      for (int n = 0; n <= FU_LATENCY; n++) w_inflight = w_inflight | r_pipe[n].v;
   end
   s_register_scoreboard u_sb (
      .clk       (clk),
      .rst       (rst),
      .i_AddrJ   (w_p.j),
      .i_AddrK   (w_p.k),
      .i_AddrDbg (bus.i_RdAddr),
      .o_DataJ   (w_sj),
      .o_DataK   (w_sk),
      .o_DataDbg (bus.o_RdData),
      .i_WbEn    (w_tail.v),
      .i_WbAddr  (w_tail.d),
      .i_WbData  (bus.i_Si),
      .i_LdEn    (w_ld),
      .i_LdAddr  (bus.i_LdAddr),
      .i_LdData  (bus.i_LdData),
      .i_SetEn   (w_issue),
      .i_SetAddr (w_p.i),
      .i_ClrEn   (w_tail.v),
      .i_ClrAddr (w_tail.d),
      .o_Busy    (w_busy)
   );
   // 106 selects popcount/parity through k[0]; 107 needs no second operand
   always_ff @(posedge clk) begin
      if (rst) begin
         r_Sj      <= '0;
         r_Sk      <= '0;
         r_Instr   <= '0;
         r_Illegal <= 1'b0;
         r_pipe    <= '0;
      end else begin
         r_Instr   <= w_issue ? w_p.opcode : '0;
         r_Illegal <= w_acc & ~w_legal;
         r_pipe    <= {r_pipe[FU_LATENCY-1:0], w_new};
         if (w_issue) begin
            r_Sj <= w_sj;
            r_Sk <= w_usek ? w_sk : {63'b0, (w_p.opcode == OP_POP) & w_p.k[0]};
         end
      end
   end
endmodule

// File: tb/tb_scalar_integer_issue.sv
// tb_scalar_integer_issue: directed vector table plus hazard, illegal and reset sequences
module tb_scalar_integer_issue;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;
   scalar_integer_issue_if bus();
   scalar_integer_issue dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   logic [63:0] fu_sj, fu_sk;
   logic [6:0]  fu_op = 7'd0;

   function automatic logic [63:0] fu(input logic [6:0] op, input logic [63:0] a, input logic [63:0] b);
      int z;
      case (op)
         7'o104: return a + b;
         7'o105: return a - b;
         7'o106: return b[0] ? {63'b0, ^a} : 64'($countones(a));
         default: begin
            z = 64;
            for (int q = 0; q < 64; q++) if (a[q]) z = 63 - q;
            return 64'(z);
         end
      endcase
   endfunction

   // functional unit: samples operands one edge after issue, presents the result one edge later
   always @(posedge clk) begin
      fu_sj <= bus.o_Sj;
      fu_sk <= bus.o_Sk;
      fu_op <= bus.o_Instr;
      if (fu_op != 7'd0) bus.i_Si <= fu(fu_op, fu_sj, fu_sk);
   end

   typedef struct {
      logic [6:0]  op;
      logic [2:0]  i, j, k;
      logic [63:0] sj, sk, esk, res;
   } vec_t;
   vec_t v[8];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ld(input logic [2:0] a, input logic [63:0] d);
      bus.i_LdValid = 1'b1;
      bus.i_LdAddr  = a;
      bus.i_LdData  = d;
      step();
      bus.i_LdValid = 1'b0;
   endtask

   task automatic rd_chk(input string nm, input logic [2:0] a, input logic [63:0] exp);
      bus.i_RdAddr = a;
      #1;
      chk(nm, bus.o_RdData, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      v[0] = '{7'o104, 3'd3, 3'd1, 3'd2, 64'd5, 64'd3, 64'd3, 64'd8};
      v[1] = '{7'o105, 3'd3, 3'd1, 3'd2, 64'd5, 64'd7, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE};
      v[2] = '{7'o104, 3'd7, 3'd4, 3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 64'd0};
      v[3] = '{7'o106, 3'd5, 3'd4, 3'd0, 64'hF0, 64'h123, 64'd0, 64'd4};
      v[4] = '{7'o106, 3'd6, 3'd4, 3'd1, 64'h7, 64'h55, 64'd1, 64'd1};
      v[5] = '{7'o107, 3'd2, 3'd1, 3'd3, 64'd0, 64'd9, 64'd0, 64'd64};
      v[6] = '{7'o107, 3'd2, 3'd1, 3'd3, 64'h0000_0001_0000_0000, 64'd9, 64'd0, 64'd31};
      v[7] = '{7'o105, 3'd0, 3'd6, 3'd7, 64'd10, 64'd10, 64'd10, 64'd0};
      bus.i_Valid = 1'b0;
      bus.i_Parcel = '0;
      bus.i_LdValid = 1'b0;
      bus.i_LdAddr = '0;
      bus.i_LdData = '0;
      bus.i_RdAddr = '0;
      step();
      step();
      chk("rst_ready", {63'b0, bus.o_Ready}, 64'd0);
      chk("rst_ldready", {63'b0, bus.o_LdReady}, 64'd0);
      chk("rst_busy", {63'b0, bus.o_Busy}, 64'd0);
      chk("rst_instr", {57'b0, bus.o_Instr}, 64'd0);
      chk("rst_sj", bus.o_Sj, 64'd0);
      rd_chk("rst_rd", 3'd0, 64'd0);
      rst = 1'b0;
      step();

      for (int n = 0; n < 8; n++) begin
         ld(v[n].j, v[n].sj);
         ld(v[n].k, v[n].sk);
         bus.i_Parcel = {v[n].op, v[n].i, v[n].j, v[n].k};
         bus.i_Valid = 1'b1;
         #1;
         chk($sformatf("v%0d_ready", n), {63'b0, bus.o_Ready}, 64'd1);
         step();
         bus.i_Valid = 1'b0;
         chk($sformatf("v%0d_instr", n), {57'b0, bus.o_Instr}, {57'b0, v[n].op});
         chk($sformatf("v%0d_sj", n), bus.o_Sj, v[n].sj);
         chk($sformatf("v%0d_sk", n), bus.o_Sk, v[n].esk);
         step();
         step();
         chk($sformatf("v%0d_busy_inflight", n), {63'b0, bus.o_Busy}, 64'd1);
         step();
         rd_chk($sformatf("v%0d_result", n), v[n].i, v[n].res);
         chk($sformatf("v%0d_busy_idle", n), {63'b0, bus.o_Busy}, 64'd0);
      end

      // load request blocks issue in the same cycle
      bus.i_Parcel = {7'o104, 3'd3, 3'd1, 3'd2};
      bus.i_Valid = 1'b1;
      bus.i_LdValid = 1'b1;
      bus.i_LdAddr = 3'd6;
      bus.i_LdData = 64'hAB;
      #1;
      chk("ld_blocks_ready", {63'b0, bus.o_Ready}, 64'd0);
      step();
      bus.i_Valid = 1'b0;
      bus.i_LdValid = 1'b0;
      chk("ld_blocks_instr", {57'b0, bus.o_Instr}, 64'd0);
      rd_chk("ld_blocks_load", 3'd6, 64'hAB);

      // back-to-back independent 106 issues
      ld(3'd4, 64'hF0);
      bus.i_Parcel = {7'o106, 3'd5, 3'd4, 3'd0};
      bus.i_Valid = 1'b1;
      #1;
      chk("b2b_ready0", {63'b0, bus.o_Ready}, 64'd1);
      step();
      chk("b2b_sk0", bus.o_Sk, 64'd0);
      bus.i_Parcel = {7'o106, 3'd6, 3'd4, 3'd1};
      #1;
      chk("b2b_ready1", {63'b0, bus.o_Ready}, 64'd1);
      step();
      bus.i_Valid = 1'b0;
      chk("b2b_sk1", bus.o_Sk, 64'd1);
      chk("b2b_instr1", {57'b0, bus.o_Instr}, 64'o106);
      step();
      step();
      rd_chk("b2b_s5", 3'd5, 64'd4);
      step();
      rd_chk("b2b_s6", 3'd6, 64'd0);

      // dependent parcel waits for writeback, no bypass
      ld(3'd1, 64'd0);
      bus.i_Parcel = {7'o107, 3'd2, 3'd1, 3'd0};
      bus.i_Valid = 1'b1;
      step();
      bus.i_Parcel = {7'o104, 3'd3, 3'd2, 3'd2};
      bus.i_LdAddr = 3'd2;
      #1;
      chk("dep_ldready_busy", {63'b0, bus.o_LdReady}, 64'd0);
      for (int e = 1; e <= 3; e++) begin
         chk($sformatf("dep_stall_t%0d", e), {63'b0, bus.o_Ready}, 64'd0);
         step();
      end
      rd_chk("dep_s2", 3'd2, 64'd64);
      chk("dep_ready_t4", {63'b0, bus.o_Ready}, 64'd1);
      step();
      bus.i_Valid = 1'b0;
      chk("dep_sj", bus.o_Sj, 64'd64);
      chk("dep_instr", {57'b0, bus.o_Instr}, 64'o104);
      step();
      step();
      step();
      rd_chk("dep_s3", 3'd3, 64'd128);

      // illegal opcode
      bus.i_Parcel = {7'o000, 3'd7, 3'd1, 3'd2};
      bus.i_Valid = 1'b1;
      #1;
      chk("ill_ready", {63'b0, bus.o_Ready}, 64'd1);
      step();
      bus.i_Valid = 1'b0;
      chk("ill_pulse", {63'b0, bus.o_Illegal}, 64'd1);
      chk("ill_instr", {57'b0, bus.o_Instr}, 64'd0);
      chk("ill_busy", {63'b0, bus.o_Busy}, 64'd0);
      step();
      chk("ill_pulse_end", {63'b0, bus.o_Illegal}, 64'd0);

      // reset one cycle after an issue discards the in-flight result
      ld(3'd1, 64'd9);
      bus.i_Parcel = {7'o104, 3'd4, 3'd1, 3'd1};
      bus.i_Valid = 1'b1;
      step();
      bus.i_Valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_instr", {57'b0, bus.o_Instr}, 64'd0);
      chk("mid_rst_sj", bus.o_Sj, 64'd0);
      rd_chk("mid_rst_s1", 3'd1, 64'd0);
      step();
      step();
      step();
      rd_chk("mid_rst_s4", 3'd4, 64'd0);
      chk("mid_rst_busy", {63'b0, bus.o_Busy}, 64'd0);
      bus.i_LdAddr = 3'd4;
      #1;
      chk("mid_rst_ldready", {63'b0, bus.o_LdReady}, 64'd1);
      ld(3'd4, 64'd77);
      rd_chk("mid_rst_load", 3'd4, 64'd77);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
